// File: rtl/gate_arb_pkg.sv
// Shared definitions for gate_eval_arbiter: opcodes, sequencer states, statistics width.
package gate_arb_pkg;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/gate_eval_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NREQ-1.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            any_valid
);

  // One spare bit holds ptr+offset before the explicit wrap, so NREQ need not be a power of two.
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // NOTE: every output gets a default before the loop; a path that skips an assignment would infer a latch.
  always_comb begin
    onehot    = '0;
    idx       = '0;
    any_valid = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum = {1'b0, ptr} + (IDW+1)'(off);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (!any_valid && req[cand]) begin
        any_valid    = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/gate_eval_arbiter.sv
// Round-robin sequencer sharing one OR/NOR/AND/NAND unit among NREQ requesters, registered tagged result.
// Optional per-requester grant counters when GATE_ARB_STATS_EN is defined.
module gate_eval_arbiter
  import gate_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    a_in,
  input  logic [NREQ*W-1:0]    b_in,
  input  logic [NREQ*2-1:0]    op_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [W-1:0]         res_data
`ifdef GATE_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [NREQ*STAT_W-1:0] stat_cnt
`endif
);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [W-1:0]   res_data_q, res_data_d;

  logic [NREQ-1:0] pick_onehot;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            issue;
  logic            grant;
  logic [W-1:0]    a_sel, b_sel, eval;
  logic [1:0]      op_sel;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .onehot    (pick_onehot),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // A free or draining result register can accept a new result; rst_n gates grants during reset.
  assign issue = (state_q == ST_EMPTY) || res_ready;
  assign grant = rst_n && issue && pick_any;
  assign gnt   = grant ? pick_onehot : '0;

  assign a_sel  = a_in[pick_idx*W +: W];
  assign b_sel  = b_in[pick_idx*W +: W];
  assign op_sel = op_in[pick_idx*2 +: 2];

  always_comb begin
    eval = a_sel | b_sel;
    case (op_sel)
      OP_OR:   eval = a_sel | b_sel;
      OP_NOR:  eval = ~(a_sel | b_sel);
      OP_AND:  eval = a_sel & b_sel;
      OP_NAND: eval = ~(a_sel & b_sel);
      default: eval = a_sel | b_sel;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    res_id_d   = res_id_q;
    res_data_d = res_data_q;
    if (grant) begin
      state_d    = ST_HOLD;
      res_data_d = eval;
      res_id_d   = pick_idx;
      ptr_d      = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
    end else if (state_q == ST_HOLD && res_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      res_id_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
    end
  end

  assign res_valid = (state_q == ST_HOLD);
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

`ifdef GATE_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NREQ];

  // NOTE: the counter array is small and architecturally visible, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (grant && cnt_q[pick_idx] != {STAT_W{1'b1}}) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + 1'b1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Self-checking bench for gate_eval_arbiter: reference model predicts grants, scoreboard checks results.
module tb_gate_eval_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in, b_in;
  logic [NREQ*2-1:0] op_in;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_data;
`ifdef GATE_ARB_STATS_EN
  logic              stat_clr;
  logic [NREQ*16-1:0] stat_cnt;
`endif

  gate_eval_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_in     (op_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data)
`ifdef GATE_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] eval_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return ~(a | b);
      2'd2:    return a & b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int rr_model(input logic [NREQ-1:0] r, input int p);
    for (int o = 0; o < NREQ; o++) begin
      if (r[(p + o) % NREQ]) return (p + o) % NREQ;
    end
    return -1;
  endfunction

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } sb_t;

  sb_t sb_q[$];
  int  ptr_m   = 0;
  bit  valid_m = 1'b0;
  bit  pending = 1'b0;
  int  last_id = 0;

  // Reference model: predicts gnt and res_valid each cycle, pushes the expected result on each grant.
  always @(negedge clk) begin
    int k;
    logic [NREQ-1:0] exp_gnt;
    sb_t e;
    if (!rst_n) begin
      sb_q.delete();
      ptr_m   = 0;
      valid_m = 1'b0;
      pending = 1'b0;
    end else begin
      if (pending) begin
        check("res_valid_after_grant", 32'(res_valid), 32'd1);
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("res_id", 32'(res_id), 32'(e.id));
          check("res_data", 32'(res_data), 32'(e.data));
          last_id = int'(e.id);
        end
      end
      check("res_valid", 32'(res_valid), 32'(valid_m));
      k = (!valid_m || res_ready) ? rr_model(req, ptr_m) : -1;
      exp_gnt = (k >= 0) ? (NREQ'(1) << k) : '0;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      pending = 1'b0;
      if (k >= 0) begin
        e.id   = IDW'(k);
        e.data = eval_model(op_in[k*2 +: 2], a_in[k*W +: W], b_in[k*W +: W]);
        sb_q.push_back(e);
        ptr_m   = (k == NREQ-1) ? 0 : k + 1;
        valid_m = 1'b1;
        pending = 1'b1;
      end else if (res_ready) begin
        valid_m = 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    op_in[i*2 +: 2] = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] ord [5];
    logic [W-1:0]    tbl [4];
    ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tbl = '{8'hEE, 8'h11, 8'h88, 8'h77};

    rst_n     = 1'b0;
    req       = '1;
    res_ready = 1'b1;
    a_in      = {NREQ{8'h5A}};
    b_in      = {NREQ{8'hC3}};
    op_in     = '0;
`ifdef GATE_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif

    // Reset state, with all requesters active to confirm no grant during reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    #2;
    rst_n = 1'b1;
    req   = '0;
    step();

    // Single OR transaction from requester 0
    set_req(0, 8'hF0, 8'h0F, 2'b00);
    req = 4'b0001;
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'h1);
    step();
    req = '0;
    @(negedge clk);
    check("t1_valid", 32'(res_valid), 32'd1);
    check("t1_id", 32'(res_id), 32'd0);
    check("t1_data", 32'(res_data), 32'hFF);
    step();
    step();

    // Move ptr back to 0 through requester 3
    set_req(3, 8'h3C, 8'h66, 2'b10);
    req = 4'b1000;
    step();
    req = '0;
    step();
    step();

    // All four requesting continuously: order 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_req(i, W'($urandom), W'($urandom), 2'($urandom));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_order", 32'(gnt), 32'(ord[i]));
      step();
    end
    req = '0;
    step();
    step();

    // Opcode sweep on requester 0, back to back
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        set_req(0, 8'hAA, 8'hCC, 2'(k));
        req = 4'b0001;
      end else begin
        req = '0;
      end
      @(negedge clk);
      if (k > 0) check("t3_opcode", 32'(res_data), 32'(tbl[k-1]));
      step();
    end
    step();

    // Backpressure stall for 3 cycles with all requesting
    for (int i = 0; i < NREQ; i++) set_req(i, W'($urandom), W'($urandom), 2'($urandom));
    req = 4'b1111;
    step();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("t4_stall_gnt", 32'(gnt), 32'd0);
      check("t4_stall_id", 32'(res_id), 32'(last_id));
      check("t4_stall_valid", 32'(res_valid), 32'd1);
      step();
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t4_next_gnt", 32'(gnt), 32'(NREQ'(1) << ((last_id + 1) % NREQ)));
    step();
    req = '0;
    step();
    step();

    // Asynchronous reset while a result is held
    req = 4'b1111;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(res_valid), 32'd0);
    check("t5_async_gnt", 32'(gnt), 32'd0);
    check("t5_async_data", 32'(res_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1010;
    @(negedge clk);
    check("t5_first_gnt", 32'(gnt), 32'h2);
    step();
    req = '0;
    step();
    step();

`ifdef GATE_ARB_STATS_EN
    // Saturating grant counter and synchronous clear
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    check("stat_clr_init", 32'(stat_cnt[2*16 +: 16]), 32'd0);
    set_req(2, 8'h12, 8'h34, 2'b11);
    req = 4'b0100;
    repeat (65540) step();
    req = '0;
    step();
    @(negedge clk);
    check("stat_saturate", 32'(stat_cnt[2*16 +: 16]), 32'hFFFF);
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    check("stat_clear", 32'(stat_cnt[2*16 +: 16]), 32'd0);
    step();
`endif

    step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
